// File: rtl/game_pkg.sv
// Shared definitions for the score/high-score datapath: digit geometry, blink timing
// defaults and the high-score compare FSM encoding.
package game_pkg;

    localparam int unsigned DEF_DIGITS       = 6;
    localparam int unsigned BCD_W            = 4;
    localparam int unsigned DEF_BLINK_CYCLES = 25_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP    = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/blink_timer.sv
// Half-period counter and phase bit for the new-record LED blink.
// restart forces a fresh lit half-period, so a new record always starts with the LED on.
module blink_timer
    import game_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = DEF_BLINK_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (!enable) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_W'(BLINK_CYCLES - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/high_score_tracker.sv
// Snapshots the BCD run score on gameover, compares it MSD-first against the stored high
// score, updates the high score / new-record flag, and registers the hex display value.
module high_score_tracker
    import game_pkg::*;
#(
    parameter int unsigned DIGITS       = DEF_DIGITS,
    parameter int unsigned BLINK_CYCLES = DEF_BLINK_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BCD_W*DIGITS-1:0] score_bcd,
    input  logic                    gameover,
    input  logic                    show_high,
    output logic [BCD_W*DIGITS-1:0] high_bcd,
    output logic [BCD_W*DIGITS-1:0] disp_bcd,
    output logic                    new_record,
    output logic                    new_record_blink,
    output logic                    busy
);

    localparam int unsigned SCORE_W = BCD_W * DIGITS;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state;
    state_t             state_next;
    logic               gameover_d;
    logic [SCORE_W-1:0] snap;
    logic [IDX_W-1:0]   idx;
    logic [BCD_W-1:0]   snap_dig_c;
    logic [BCD_W-1:0]   high_dig_c;
    logic               rise_c;
    logic               fall_c;
    logic               load_c;
    logic               step_c;
    logic               update_c;
    logic               clear_c;
    logic               phase;

    assign rise_c = gameover & ~gameover_d;
    assign fall_c = ~gameover & gameover_d;

    // Digit under comparison; idx never exceeds DIGITS-1.
    always_comb begin
        snap_dig_c = '0;
        high_dig_c = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                snap_dig_c = snap[i*BCD_W +: BCD_W];
                high_dig_c = high_bcd[i*BCD_W +: BCD_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        update_c   = 1'b0;
        clear_c    = 1'b0;
        case (state)
            IDLE: begin
                if (rise_c) begin
                    load_c     = 1'b1;
                    state_next = CMP;
                end else if (fall_c) begin
                    clear_c = 1'b1;
                end
            end
            CMP: begin
                if (snap_dig_c > high_dig_c) begin
                    state_next = UPDATE;
                end else if (snap_dig_c < high_dig_c) begin
                    state_next = DONE;
                end else if (idx == '0) begin
                    state_next = DONE;
                end else begin
                    step_c = 1'b1;
                end
            end
            UPDATE: begin
                update_c   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Snapshot, digit index, high score, flag and busy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gameover_d <= 1'b0;
            snap       <= '0;
            idx        <= '0;
            high_bcd   <= '0;
            new_record <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gameover_d <= gameover;
            busy       <= (state_next != IDLE);
            if (load_c) begin
                snap <= score_bcd;
                idx  <= IDX_W'(DIGITS - 1);
            end
            if (step_c) begin
                idx <= idx - IDX_W'(1);
            end
            if (update_c) begin
                high_bcd   <= snap;
                new_record <= 1'b1;
            end else if (clear_c) begin
                new_record <= 1'b0;
            end
        end
    end

    // Display register samples the pre-update high score in the UPDATE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_bcd <= '0;
        end else begin
            disp_bcd <= show_high ? high_bcd : score_bcd;
        end
    end

    blink_timer #(
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_blink_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (new_record),
        .restart (update_c),
        .phase   (phase)
    );

    assign new_record_blink = new_record & phase;

endmodule

// File: tb/tb_high_score_tracker.sv
// Directed bench for high_score_tracker: compare outcomes go through a scoreboard checked on
// each busy falling edge; reset, display and blink behaviour are checked inline.
module tb_high_score_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] score_bcd = '0;
    logic        gameover = 1'b0;
    logic        show_high = 1'b0;
    logic [23:0] high_bcd;
    logic [23:0] disp_bcd;
    logic        new_record;
    logic        new_record_blink;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [23:0] high;
        logic        nr;
        int          len;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    high_score_tracker #(
        .DIGITS       (6),
        .BLINK_CYCLES (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .score_bcd        (score_bcd),
        .gameover         (gameover),
        .show_high        (show_high),
        .high_bcd         (high_bcd),
        .disp_bcd         (disp_bcd),
        .new_record       (new_record),
        .new_record_blink (new_record_blink),
        .busy             (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [23:0] high, input logic nr, input int len);
        exp_t e;
        e.high = high;
        e.nr   = nr;
        e.len  = len;
        sb.push_back(e);
    endtask

    // Bounded wait for a compare to start and finish; leaves us just after a negedge.
    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 5);
        chk({name, "_start"}, 32'(busy), 32'd1);
        n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_end"}, 32'(busy), 32'd0);
    endtask

    // Monitor: measure each busy pulse and check the outcome it left behind.
    int   blen   = 0;
    logic busy_q = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            blen   = 0;
            busy_q = 1'b0;
        end else begin
            if (busy) begin
                blen++;
            end else if (busy_q) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_unexpected: compare of %0d cycles with none expected", blen);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_high", 32'(high_bcd), 32'(e.high));
                    chk("sb_new_record", 32'(new_record), 32'(e.nr));
                    chk("sb_busy_len", 32'(blen), 32'(e.len));
                end
                blen = 0;
            end
            busy_q = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        step(2);
        reset = 1'b0;
        chk("rst_high", 32'(high_bcd), 32'h0);
        chk("rst_disp", 32'(disp_bcd), 32'h0);
        chk("rst_new_record", 32'(new_record), 32'd0);
        chk("rst_blink", 32'(new_record_blink), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Live display, then an asynchronous reset pulse mid-cycle.
        score_bcd = 24'h000555;
        step(2);
        @(negedge clk);
        chk("disp_live", 32'(disp_bcd), 32'h000555);
        step();
        reset = 1'b1;
        #1;
        chk("t1_async_disp", 32'(disp_bcd), 32'h0);
        chk("t1_async_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;

        // First record: 000123 beats 000000, decided at digit 2.
        score_bcd = 24'h000123;
        gameover  = 1'b1;
        push(24'h000123, 1'b1, 6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (new_record !== 1'b1 && n < 10);
        chk("t2_nr_latency", 32'(n), 32'd7);
        chk("t2_high", 32'(high_bcd), 32'h000123);
        for (int i = 0; i < 16; i++) begin
            chk("t2_blink", 32'(new_record_blink), 32'(((i / 4) % 2) == 0));
            @(negedge clk);
        end
        step();
        show_high = 1'b1;
        step();
        @(negedge clk);
        chk("t2_disp_high", 32'(disp_bcd), 32'h000123);
        step();
        show_high = 1'b0;

        // New game clears the flag; 000099 loses at digit 2.
        gameover = 1'b0;
        step();
        @(negedge clk);
        chk("t3_nr_clear", 32'(new_record), 32'd0);
        chk("t3_blink_clear", 32'(new_record_blink), 32'd0);
        step();
        score_bcd = 24'h000099;
        gameover  = 1'b1;
        push(24'h000123, 1'b0, 5);
        wait_done("t3");
        step();

        // Tie walks all six digits and is not a record.
        gameover = 1'b0;
        step();
        score_bcd = 24'h000123;
        gameover  = 1'b1;
        push(24'h000123, 1'b0, 7);
        wait_done("t4");
        step();

        // 099999 beats 000123 at digit 4.
        gameover = 1'b0;
        step();
        score_bcd = 24'h099999;
        gameover  = 1'b1;
        push(24'h099999, 1'b1, 4);
        wait_done("t5a");
        step();

        // 100000 beats 099999 at the MSD; gameover toggles while busy.
        gameover = 1'b0;
        step();
        score_bcd = 24'h100000;
        show_high = 1'b1;
        gameover  = 1'b1;
        push(24'h100000, 1'b1, 3);
        step();
        gameover = 1'b0;
        step();
        gameover = 1'b1;
        @(negedge clk);
        chk("t5_nr_pre", 32'(new_record), 32'd0);
        @(negedge clk);
        chk("t5_high", 32'(high_bcd), 32'h100000);
        chk("t5_nr", 32'(new_record), 32'd1);
        chk("t5_disp_old", 32'(disp_bcd), 32'h099999);
        @(negedge clk);
        chk("t5_disp_new", 32'(disp_bcd), 32'h100000);
        repeat (6) @(negedge clk);
        chk("t5_nr_held", 32'(new_record), 32'd1);
        chk("t5_idle", 32'(busy), 32'd0);
        step();

        // Reset during a compare aborts it and loses the high score.
        gameover = 1'b0;
        step();
        score_bcd = 24'h100001;
        gameover  = 1'b1;
        step(2);
        chk("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_high", 32'(high_bcd), 32'h0);
        chk("t6_nr", 32'(new_record), 32'd0);
        chk("t6_disp", 32'(disp_bcd), 32'h0);
        gameover = 1'b0;
        step(2);
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("t6_disp_high", 32'(disp_bcd), 32'h0);
        chk("t6_idle", 32'(busy), 32'd0);

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
